spi_sync_fifo: RTL
==================

SPI_SYNC_FIFO -- requirements
Module: spi_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits (>=1).
REQ-002 Parameter FIFO_DEPTH, default 16, number of entries; power of two, >=2.
REQ-003 Parameter AFULL_THRESH, default 12, almost_full asserts when level >= AFULL_THRESH.
REQ-004 Parameter AEMPTY_THRESH, default 4, almost_empty asserts when level <= AEMPTY_THRESH.
REQ-005 Parameter FWFT, default 1; 1 = show-ahead read, 0 = registered read with one-cycle latency.
REQ-006 Localparam ADDR_WIDTH = $clog2(FIFO_DEPTH); level is ADDR_WIDTH+1 bits wide.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 write_en  input  1  write request.
REQ-010 write_data  input  DATA_WIDTH  word to write.
REQ-011 read_en  input  1  read (pop) request.
REQ-012 read_data  output  DATA_WIDTH  read word.
REQ-013 read_valid  output  1  read_data is valid (FWFT=1: equals !empty; FWFT=0: pulse one cycle after an accepted read).
REQ-014 flush  input  1  synchronous clear of contents.
REQ-015 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-016 empty, full, almost_empty, almost_full  output  1 each  status flags.
REQ-017 level  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH.
REQ-018 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-019 Write accepted (wr_acc) = write_en && (!full || rd_acc); the word is stored at wr_ptr and wr_ptr increments modulo FIFO_DEPTH.
REQ-020 Read accepted (rd_acc) = read_en && !empty; rd_ptr increments modulo FIFO_DEPTH.
REQ-021 Simultaneous wr_acc and rd_acc leave level unchanged; when full, a simultaneous write and read both succeed.
REQ-022 When empty, a simultaneous write and read accept only the write; underflow sets.
REQ-023 level +1 on write only, -1 on read only, unchanged otherwise; it never exceeds FIFO_DEPTH and never drops below 0.
REQ-024 empty = (level==0); full = (level==FIFO_DEPTH); almost flags derive from level per REQ-003/004, all combinational from the registered level.
REQ-025 FWFT=1: read_data = mem[rd_ptr] combinationally; read_valid = !empty.
REQ-026 FWFT=0: on rd_acc, read_data registers mem[rd_ptr] and read_valid pulses high for the next cycle; otherwise read_data holds and read_valid = 0.
REQ-027 overflow sets on write_en while full without rd_acc; underflow sets on read_en while empty; both stay set until clr_err or reset.
REQ-028 clr_err clears a flag unless a new error occurs in the same cycle, in which case the flag remains set.
REQ-029 flush zeroes wr_ptr, rd_ptr and level in the next cycle; it takes priority over same-cycle write_en and read_en, which are ignored and raise no error flags.
REQ-030 Memory contents are not reset; reads of unwritten locations are impossible because empty gates them.

Reset
REQ-031 When rst_n is low: wr_ptr = rd_ptr = 0, level = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = underflow = 0, read_valid = 0, and read_data = 0 when FWFT=0.
REQ-032 Reset mid-operation discards all stored words; the first write after rst_n deasserts is the first word read.

Structure
REQ-033 The shared SPI package/header holds the default DATA_WIDTH and FIFO_DEPTH constants used by the TX and RX instances.
REQ-034 Storage is a sub-module spi_fifo_ram: one write port, one asynchronous read port, no reset.
REQ-035 Pointer, level and flag logic and the FWFT output stage stay in spi_sync_fifo.

Verification
REQ-036 Reset, then write 0x11..0x1F and 0x10 (16 words) -> full=1, level=16, almost_full from level 12; reads return 0x11..0x1F, 0x10 in order.
REQ-037 Write while full with no read -> word dropped, overflow=1, level stays 16; clr_err -> overflow=0.
REQ-038 Full, then write 0xAA and read in the same cycle -> level stays 16; 0xAA is read out last.
REQ-039 Empty, then write 0x5A and read in the same cycle -> level=1, underflow=1; FWFT=1: read_data=0x5A next cycle.
REQ-040 FWFT=0, level 3 (0x01,0x02,0x03), read once -> read_valid high exactly one cycle later with read_data=0x01.
REQ-041 Level 9, then flush with write_en=1 -> next cycle level=0, empty=1, no error flags; rst_n low mid-burst -> all outputs return to REQ-031 values.

Source files
------------

// File: rtl/spi_sync_fifo_pkg.sv
// Constants and types shared by the SPI TX/RX FIFO instances.
package spi_sync_fifo_pkg;

    localparam int SPI_DATA_WIDTH = 8;
    localparam int SPI_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_INC  = 2'd1,
        LVL_DEC  = 2'd2
    } lvl_op_e;

endpackage

// File: rtl/spi_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module spi_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO for the SPI datapath: pointers, occupancy, status/error flags
// and a selectable show-ahead or registered read stage.
module spi_sync_fifo
    import spi_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = SPI_DATA_WIDTH,
    parameter int FIFO_DEPTH    = SPI_FIFO_DEPTH,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          write_en,
    input  logic [DATA_WIDTH-1:0]         write_data,
    input  logic                          read_en,
    output logic [DATA_WIDTH-1:0]         read_data,
    output logic                          read_valid,
    input  logic                          flush,
    input  logic                          clr_err,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int LVL_W      = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [LVL_W-1:0]      level_q;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ovf_evt;
    logic                  udf_evt;
    lvl_op_e               lvl_op;

    assign level        = level_q;
    assign empty        = (level_q == '0);
    assign full         = (level_q == LVL_W'(FIFO_DEPTH));
    assign almost_empty = (level_q <= LVL_W'(AEMPTY_THRESH));
    assign almost_full  = (level_q >= LVL_W'(AFULL_THRESH));

    // Flush masks both requests so they neither move pointers nor raise errors.
    assign rd_acc  = read_en && !empty && !flush;
    assign wr_acc  = write_en && (!full || rd_acc) && !flush;
    assign ovf_evt = write_en && full && !rd_acc && !flush;
    assign udf_evt = read_en && empty && !flush;

    always_comb begin
        lvl_op = LVL_HOLD;
        if (wr_acc && !rd_acc) begin
            lvl_op = LVL_INC;
        end else if (rd_acc && !wr_acc) begin
            lvl_op = LVL_DEC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case (lvl_op)
                LVL_INC: level_q <= level_q + LVL_W'(1);
                LVL_DEC: level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // A new error in the same cycle as clr_err wins, so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (udf_evt) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    spi_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (write_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    generate
        if (FWFT != 0) begin : g_show_ahead
            assign read_data  = ram_rdata;
            assign read_valid = !empty;
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= ram_rdata;
                    end
                end
            end

            assign read_data  = rd_data_q;
            assign read_valid = rd_valid_q;
        end
    endgenerate

endmodule
